// File: rtl/fetch_controller.sv
// Fetch stage controller: PC sequencing, decode pipeline register and a RUN/HALT/STEP debug FSM.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module fetch_controller #(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BITS_DATA-1:0] InstrF,
    input  logic                 StallF,
    input  logic                 StallD,
    input  logic                 FlushD,
    input  logic                 PCSrcE,
    input  logic [BITS_ADDR-1:0] PCTargetE,
    input  logic                 halt_req,
    input  logic                 step_req,
    input  logic                 resume_req,
    output logic [BITS_ADDR-1:0] PCF,
    output logic [BITS_DATA-1:0] InstrD,
    output logic [BITS_ADDR-1:0] PCD,
    output logic                 ValidD,
    output logic                 halted,
    output logic [31:0]          instr_count,
    output logic [31:0]          stall_count
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [BITS_ADDR-1:0] pcf_q, pcf_d;
    logic [BITS_DATA-1:0] dec_instr_q, dec_instr_d;
    logic [BITS_ADDR-1:0] dec_pc_q, dec_pc_d;
    logic                 dec_valid_q, dec_valid_d;
    logic                 fetch_en;
    logic                 issue;

    assign fetch_en = (state_q == ST_RUN) || (state_q == ST_STEP);
    // An instruction is issued when the decode register loads a real fetch.
    assign issue    = !(PCSrcE || FlushD) && !StallD && fetch_en && !StallF;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (halt_req) state_d = ST_HALT;
            end
            ST_HALT: begin
                if (resume_req)    state_d = ST_RUN;
                else if (step_req) state_d = ST_STEP;
            end
            ST_STEP: begin
                if (!StallF && !PCSrcE) state_d = ST_HALT;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        pcf_d = pcf_q;
        if (PCSrcE)                     pcf_d = PCTargetE;
        else if (!StallF && fetch_en)   pcf_d = pcf_q + 1'b1;
    end

    always_comb begin
        dec_instr_d = dec_instr_q;
        dec_pc_d    = dec_pc_q;
        dec_valid_d = dec_valid_q;
        if (PCSrcE || FlushD) begin
            dec_instr_d = '0;
            dec_pc_d    = '0;
            dec_valid_d = 1'b0;
        end else if (!StallD) begin
            dec_instr_d = InstrF;
            dec_pc_d    = pcf_q;
            dec_valid_d = fetch_en && !StallF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            pcf_q       <= '0;
            dec_instr_q <= '0;
            dec_pc_q    <= '0;
            dec_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pcf_q       <= pcf_d;
            dec_instr_q <= dec_instr_d;
            dec_pc_q    <= dec_pc_d;
            dec_valid_q <= dec_valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] instr_count_q, instr_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        instr_count_d = instr_count_q;
        stall_count_d = stall_count_q;
        if (issue)                                instr_count_d = instr_count_q + 32'd1;
        if ((state_q == ST_RUN) && StallF)        stall_count_d = stall_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            instr_count_q <= instr_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign instr_count = instr_count_q;
    assign stall_count = stall_count_q;
`else
    logic unused_issue;
    assign unused_issue = issue;
    assign instr_count  = 32'd0;
    assign stall_count  = 32'd0;
`endif

    assign PCF    = pcf_q;
    assign InstrD = dec_instr_q;
    assign PCD    = dec_pc_q;
    assign ValidD = dec_valid_q;
    assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed self-checking bench for fetch_controller; ROM model returns word n = n + 0x100.
module tb_fetch_controller;
    localparam int BITS_DATA = 32;
    localparam int BITS_ADDR = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [BITS_DATA-1:0] InstrF;
    logic                 StallF, StallD, FlushD, PCSrcE;
    logic [BITS_ADDR-1:0] PCTargetE;
    logic                 halt_req, step_req, resume_req;
    logic [BITS_ADDR-1:0] PCF;
    logic [BITS_DATA-1:0] InstrD;
    logic [BITS_ADDR-1:0] PCD;
    logic                 ValidD;
    logic                 halted;
    logic [31:0]          instr_count, stall_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_instr = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    assign InstrF = 32'h100 + 32'(PCF);

    fetch_controller #(.BITS_DATA(BITS_DATA), .BITS_ADDR(BITS_ADDR)) dut (
        .clk(clk), .reset(reset), .InstrF(InstrF),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .halt_req(halt_req), .step_req(step_req), .resume_req(resume_req),
        .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .ValidD(ValidD),
        .halted(halted), .instr_count(instr_count), .stall_count(stall_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_dec(input string tag, input int pcf, input int instr, input int pcd, input int vld);
        check({tag, "_pcf"},   32'(PCF),    32'(pcf));
        check({tag, "_instr"}, InstrD,      32'(instr));
        check({tag, "_pcd"},   32'(PCD),    32'(pcd));
        check({tag, "_valid"}, 32'(ValidD), 32'(vld));
    endtask

    task automatic check_cnt(input string tag);
`ifdef FETCH_PERF_CNT_EN
        check({tag, "_icnt"}, instr_count, 32'(exp_instr));
        check({tag, "_scnt"}, stall_count, 32'(exp_stall));
`else
        check({tag, "_icnt"}, instr_count, 32'd0);
        check({tag, "_scnt"}, stall_count, 32'd0);
`endif
    endtask

    initial begin
        reset = 1'b1; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
        halt_req = 0; step_req = 0; resume_req = 0;
        tick(); tick();
        reset = 1'b0;
        check_dec("rst", 0, 0, 0, 0);
        check("rst_halted", 32'(halted), 0);
        check_cnt("rst");

        // free run
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_instr++;
            check_dec("run", i + 1, 32'h100 + i, i, 1);
        end
        check_cnt("run");

        // stall at PCF=6
        tick(); tick(); exp_instr += 2;
        check_dec("pre_stall", 6, 32'h105, 5, 1);
        StallF = 1; StallD = 1;
        tick(); exp_stall++;
        check_dec("stall1", 6, 32'h105, 5, 1);
        tick(); exp_stall++;
        check_dec("stall2", 6, 32'h105, 5, 1);
        check_cnt("stall");
        StallF = 0; StallD = 0;
        tick(); exp_instr++;
        check_dec("unstall", 7, 32'h106, 6, 1);

        // redirect beats StallD
        PCSrcE = 1; PCTargetE = 5'h14; StallD = 1;
        tick();
        check_dec("redir", 32'h14, 0, 0, 0);
        PCSrcE = 0; StallD = 0;
        tick(); exp_instr++;
        check_dec("redir_next", 32'h15, 32'h114, 32'h14, 1);

        // FlushD alone
        FlushD = 1;
        tick();
        check_dec("flush", 32'h16, 0, 0, 0);
        FlushD = 0;
        tick(); exp_instr++;
        check_dec("flush_next", 32'h17, 32'h116, 32'h16, 1);

        // wrap at 31
        PCSrcE = 1; PCTargetE = 5'd31;
        tick();
        check_dec("to31", 31, 0, 0, 0);
        PCSrcE = 0;
        tick(); exp_instr++;
        check_dec("wrap", 0, 32'h11F, 31, 1);
        check_cnt("wrap");

        // halt / step / resume
        tick(); tick(); tick(); exp_instr += 3;
        check_dec("pre_halt", 3, 32'h102, 2, 1);
        halt_req = 1;
        tick(); exp_instr++;
        halt_req = 0;
        check_dec("halt", 4, 32'h103, 3, 1);
        check("halt_halted", 32'(halted), 1);
        tick();
        check("halt_frozen_pcf", 32'(PCF), 4);
        check("halt_frozen_valid", 32'(ValidD), 0);
        step_req = 1;
        tick();
        step_req = 0;
        check("step_enter_halted", 32'(halted), 0);
        check("step_enter_pcf", 32'(PCF), 4);
        check("step_enter_valid", 32'(ValidD), 0);
        tick(); exp_instr++;
        check_dec("step_issue", 5, 32'h104, 4, 1);
        check("step_issue_halted", 32'(halted), 1);
        tick();
        check("step_after_valid", 32'(ValidD), 0);
        check("step_after_pcf", 32'(PCF), 5);
        PCSrcE = 1; PCTargetE = 5'd9;
        tick();
        PCSrcE = 0;
        check_dec("halt_redir", 9, 0, 0, 0);
        check("halt_redir_halted", 32'(halted), 1);
        resume_req = 1;
        tick();
        resume_req = 0;
        check("resume_halted", 32'(halted), 0);
        check("resume_pcf", 32'(PCF), 9);
        tick(); exp_instr++;
        check_dec("resume_run", 10, 32'h109, 9, 1);
        check_cnt("resume");

        // step+resume together -> RUN
        halt_req = 1;
        tick(); exp_instr++;
        halt_req = 0;
        check("halt2_halted", 32'(halted), 1);
        check("halt2_pcf", 32'(PCF), 11);
        step_req = 1; resume_req = 1;
        tick();
        step_req = 0; resume_req = 0;
        check("both_halted", 32'(halted), 0);
        check("both_pcf", 32'(PCF), 11);
        tick(); exp_instr++;
        check_dec("both_run", 12, 32'h10B, 11, 1);

        // reset during stalled STEP
        halt_req = 1;
        tick(); exp_instr++;
        halt_req = 0;
        check("halt3_pcf", 32'(PCF), 13);
        step_req = 1;
        tick();
        step_req = 0;
        StallF = 1; halt_req = 1;
        tick();
        check("step_stall_halted", 32'(halted), 0);
        check("step_stall_pcf", 32'(PCF), 13);
        check("step_stall_valid", 32'(ValidD), 0);
        check_cnt("step_stall");
        reset = 1;
        tick();
        exp_instr = 0; exp_stall = 0;
        check_dec("rst2", 0, 0, 0, 0);
        check("rst2_halted", 32'(halted), 0);
        check_cnt("rst2");
        reset = 0; StallF = 0; halt_req = 0;
        tick(); exp_instr++;
        check_dec("rst2_run", 1, 32'h100, 0, 1);
        check("rst2_run_halted", 32'(halted), 0);
        check_cnt("rst2_run");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
